// File: rtl/snake_upd_if.sv
// Move-request handshake between the game controller and snake_renderer.
// The master issues moves; the renderer is the slave and reports readiness.
interface snake_upd_if;
   logic       upd_valid;
   logic       upd_ready;
   logic [1:0] upd_dir;
   logic       upd_grow;

   modport master (output upd_valid, output upd_dir, output upd_grow, input upd_ready);
   modport slave  (input upd_valid, input upd_dir, input upd_grow, output upd_ready);
endinterface

// File: rtl/snake_renderer.sv
// Snake game state (circular segment buffer, move check FSM) and registered pixel colour
// lookup for a block grid driven by the VGA coordinate stream.
module snake_renderer #(
   parameter int unsigned MAX_LEN  = 32,
   parameter int unsigned INIT_LEN = 3,
   parameter int unsigned GRID_W   = 100,
   parameter int unsigned GRID_H   = 75,
   parameter logic [11:0] C_BORDER = 12'hFFF,
   parameter logic [11:0] C_HEAD   = 12'h0F0,
   parameter logic [11:0] C_BODY   = 12'h080,
   parameter logic [11:0] C_FOOD   = 12'hF00,
   parameter logic [11:0] C_BG     = 12'h000
) (
   input  logic        clk,
   input  logic        rstn,
   snake_upd_if.slave  upd,
   input  logic [10:0] XCoord,
   input  logic [10:0] YCoord,
   input  logic        restart,
   input  logic [6:0]  food_x,
   input  logic [6:0]  food_y,
   output logic [11:0] pixel_color,
   output logic [5:0]  length,
   output logic        collision
);
   localparam int unsigned PtrW = $clog2(MAX_LEN);

   typedef enum logic [1:0] {StIdle, StCheck, StCommit, StDead} state_e;

   state_e            state_q, state_d;
   logic [PtrW-1:0]   head_ptr_q, head_ptr_d;
   logic [5:0]        len_q, len_d;
   logic [1:0]        dir_q, dir_d;
   logic [6:0]        new_x_q, new_x_d, new_y_q, new_y_d;
   logic              grow_q, grow_d;
   logic [5:0]        idx_q, idx_d, last_q, last_d;
   logic [11:0]       pix_q, pix_d;
   logic [6:0]        seg_x_q [MAX_LEN];
   logic [6:0]        seg_y_q [MAX_LEN];

   logic [1:0]        eff_dir;
   logic [6:0]        hx, hy, nx, ny;
   logic              eff_grow, wall_hit, seg_hit;
   logic [PtrW-1:0]   cmp_ptr;

   // Segment k of the starting snake lives at physical slot (0 - k) mod MAX_LEN.
   function automatic logic [6:0] init_x(int unsigned i);
      int unsigned k;
      k = (MAX_LEN - i) % MAX_LEN;
      return (k < INIT_LEN) ? 7'(50 - k) : 7'd0;
   endfunction

   assign hx        = seg_x_q[head_ptr_q];
   assign hy        = seg_y_q[head_ptr_q];
   assign eff_dir   = (upd.upd_dir == (dir_q ^ 2'd2)) ? dir_q : upd.upd_dir;
   assign eff_grow  = upd.upd_grow && (len_q < 6'(MAX_LEN));
   assign cmp_ptr   = head_ptr_q - PtrW'(idx_q);
   assign seg_hit   = (seg_x_q[cmp_ptr] == new_x_q) && (seg_y_q[cmp_ptr] == new_y_q);
   assign wall_hit  = (nx == 7'd0) || (nx == 7'(GRID_W - 1)) ||
                      (ny == 7'd0) || (ny == 7'(GRID_H - 1));

   always_comb begin
      nx = hx;
      ny = hy;
      case (eff_dir)
         2'd0:    nx = hx + 7'd1;
         2'd1:    ny = hy - 7'd1;
         2'd2:    nx = hx - 7'd1;
         default: ny = hy + 7'd1;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      head_ptr_d = head_ptr_q;
      len_d      = len_q;
      dir_d      = dir_q;
      new_x_d    = new_x_q;
      new_y_d    = new_y_q;
      grow_d     = grow_q;
      idx_d      = idx_q;
      last_d     = last_q;
      unique case (state_q)
         StIdle: begin
            if (upd.upd_valid) begin
               new_x_d = nx;
               new_y_d = ny;
               dir_d   = eff_dir;
               grow_d  = eff_grow;
               idx_d   = 6'd0;
               // Last scanned index: the tail is skipped unless the snake grows.
               last_d  = eff_grow ? len_q - 6'd1 : len_q - 6'd2;
               state_d = wall_hit ? StDead : StCheck;
            end
         end
         StCheck: begin
            if (seg_hit) begin
               state_d = StDead;
            end else if (idx_q == last_q) begin
               state_d = StCommit;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         StCommit: begin
            head_ptr_d = head_ptr_q + PtrW'(1);
            len_d      = len_q + {5'd0, grow_q};
            state_d    = StIdle;
         end
         default: state_d = StDead;
      endcase
      if (restart) begin
         state_d    = StIdle;
         head_ptr_d = '0;
         len_d      = 6'(INIT_LEN);
         dir_d      = 2'd0;
      end
   end

   // Render path: sees only the committed buffer.
   always_comb begin
      logic [6:0] px, py;
      logic       is_wall, is_head, is_body;
      px      = XCoord[6:0];
      py      = YCoord[6:0];
      is_wall = (px == 7'd0) || (px == 7'(GRID_W - 1)) ||
                (py == 7'd0) || (py == 7'(GRID_H - 1));
      is_head = (px == hx) && (py == hy);
      is_body = 1'b0;
      for (int j = 0; j < MAX_LEN; j++) begin
         if ((6'(PtrW'(head_ptr_q - PtrW'(j))) < len_q) && (seg_x_q[j] == px) &&
             (seg_y_q[j] == py)) begin
            is_body = 1'b1;
         end
      end
      if ((XCoord >= 11'(GRID_W)) || (YCoord >= 11'(GRID_H))) pix_d = C_BG;
      else if (is_wall)                                       pix_d = C_BORDER;
      else if (is_head)                                       pix_d = C_HEAD;
      else if (is_body)                                       pix_d = C_BODY;
      else if ((px == food_x) && (py == food_y))              pix_d = C_FOOD;
      else                                                    pix_d = C_BG;
      if (restart) pix_d = C_BG;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         head_ptr_q <= '0;
         len_q      <= 6'(INIT_LEN);
         dir_q      <= 2'd0;
         new_x_q    <= 7'd0;
         new_y_q    <= 7'd0;
         grow_q     <= 1'b0;
         idx_q      <= 6'd0;
         last_q     <= 6'd0;
         pix_q      <= C_BG;
      end else begin
         state_q    <= state_d;
         head_ptr_q <= head_ptr_d;
         len_q      <= len_d;
         dir_q      <= dir_d;
         new_x_q    <= new_x_d;
         new_y_q    <= new_y_d;
         grow_q     <= grow_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         pix_q      <= pix_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_q[i] <= init_x(i);
            seg_y_q[i] <= 7'd37;
         end
      end else if (restart) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_q[i] <= init_x(i);
            seg_y_q[i] <= 7'd37;
         end
      end else if (state_q == StCommit) begin
         seg_x_q[head_ptr_d] <= new_x_q;
         seg_y_q[head_ptr_d] <= new_y_q;
      end
   end

   assign upd.upd_ready = (state_q == StIdle);
   assign pixel_color   = pix_q;
   assign length        = len_q;
   assign collision     = (state_q == StDead);
endmodule
